// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
//   Shared 640x480 @ 60 Hz VGA timing constants and helpers. The sync
//   generator, the pixel generator and the object renderers all take their
//   screen bounds from here, so one edit retimes the whole display path.
//
//   Contents:
//     VGA_*          display / porch / sync widths and the default prescale
//     VGA_H_TOTAL    pixels per line  (800)
//     VGA_V_TOTAL    lines per frame  (525)
//     VGA_*_SYNC_*   first / last coordinate of each sync pulse
//     coord_t        10-bit screen coordinate
//     sync_t         registered hsync / vsync / video_on bundle
//     decode_sync()  coordinate -> sync_t decode
// -----------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int unsigned COORD_W = 10;

    localparam int unsigned VGA_CLK_DIV   = 4;

    localparam int unsigned VGA_H_DISPLAY = 640;
    localparam int unsigned VGA_H_FRONT   = 16;
    localparam int unsigned VGA_H_SYNC    = 96;
    localparam int unsigned VGA_H_BACK    = 48;

    localparam int unsigned VGA_V_DISPLAY = 480;
    localparam int unsigned VGA_V_FRONT   = 10;
    localparam int unsigned VGA_V_SYNC    = 2;
    localparam int unsigned VGA_V_BACK    = 33;

    localparam int unsigned VGA_H_TOTAL =
        VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int unsigned VGA_V_TOTAL =
        VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam int unsigned VGA_H_SYNC_START = VGA_H_DISPLAY + VGA_H_FRONT;
    localparam int unsigned VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
    localparam int unsigned VGA_V_SYNC_START = VGA_V_DISPLAY + VGA_V_FRONT;
    localparam int unsigned VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic hsync;     // active-low
        logic vsync;     // active-low
        logic video_on;  // active-high
    } sync_t;

    // Sync pulses are active-low inside their inclusive windows; video is
    // on only inside the visible rectangle.
    function automatic sync_t decode_sync(
        input coord_t x,
        input coord_t y,
        input coord_t h_disp,
        input coord_t h_sync_first,
        input coord_t h_sync_last,
        input coord_t v_disp,
        input coord_t v_sync_first,
        input coord_t v_sync_last
    );
        sync_t s;
        s.hsync    = !((x >= h_sync_first) && (x <= h_sync_last));
        s.vsync    = !((y >= v_sync_first) && (y <= v_sync_last));
        s.video_on = (x < h_disp) && (y < v_disp);
        return s;
    endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// -----------------------------------------------------------------------------
// vga_pixel_tick
//   Free-running prescaler. Counts 0..DIV-1 and wraps; `tick` is high for the
//   last board clock of every DIV-clock period. Also used by the game-logic
//   timer, so it carries no VGA-specific logic.
//
//   Parameters:
//     DIV    board clocks per tick period (>= 2)
//   Ports:
//     clk    in   board clock
//     reset  in   asynchronous, active-high; clears the count to 0
//     tick   out  high while the count equals DIV-1
// -----------------------------------------------------------------------------
module vga_pixel_tick #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] div_cnt_q;
    logic [CNT_W-1:0] div_cnt_d;

    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        if (div_cnt_q == CNT_LAST) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    // Decoded straight from the count register: low whenever the count is 0,
    // which covers the whole reset interval for DIV >= 2.
    assign tick = (div_cnt_q == CNT_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
//   VGA raster timing source. Divides the board clock to the pixel rate,
//   runs the horizontal / vertical counters and produces registered
//   sync, blanking and frame-strobe outputs aligned with the coordinates.
//
//   Parameters:
//     CLK_DIV                              board clocks per pixel (>= 2)
//     H_DISPLAY/H_FRONT/H_SYNC/H_BACK      horizontal timing, in pixels
//     V_DISPLAY/V_FRONT/V_SYNC/V_BACK      vertical timing, in lines
//   Ports:
//     clk         in   board clock (100 MHz)
//     reset       in   asynchronous, active-high
//     pixel_x     out  horizontal count, 0..H_TOTAL-1
//     pixel_y     out  vertical count,   0..V_TOTAL-1
//     video_on    out  high inside the visible region
//     hsync       out  horizontal sync, active-low
//     vsync       out  vertical sync, active-low
//     p_tick      out  one-clk pulse on the last clock of each pixel period
//     frame_tick  out  one-clk pulse on the first (0,0) cycle after a wrap
// -----------------------------------------------------------------------------
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV   = VGA_CLK_DIV,
    parameter int unsigned H_DISPLAY = VGA_H_DISPLAY,
    parameter int unsigned H_FRONT   = VGA_H_FRONT,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BACK    = VGA_H_BACK,
    parameter int unsigned V_DISPLAY = VGA_V_DISPLAY,
    parameter int unsigned V_FRONT   = VGA_V_FRONT,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BACK    = VGA_V_BACK
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       p_tick,
    output logic       frame_tick
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t H_LAST       = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST       = coord_t'(V_TOTAL - 1);
    localparam coord_t H_DISP_C     = coord_t'(H_DISPLAY);
    localparam coord_t V_DISP_C     = coord_t'(V_DISPLAY);
    localparam coord_t H_SYNC_FIRST = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t H_SYNC_LAST  = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam coord_t V_SYNC_FIRST = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t V_SYNC_LAST  = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic   pix_tick;

    coord_t h_cnt_q;
    coord_t h_cnt_d;
    coord_t v_cnt_q;
    coord_t v_cnt_d;
    sync_t  sync_q;
    sync_t  sync_d;
    logic   frame_tick_q;
    logic   frame_tick_d;

    vga_pixel_tick #(
        .DIV (CLK_DIV)
    ) u_pixel_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (pix_tick)
    );

    always_comb begin
        h_cnt_d      = h_cnt_q;
        v_cnt_d      = v_cnt_q;
        frame_tick_d = 1'b0;
        if (pix_tick) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d      = '0;
                    frame_tick_d = 1'b1;
                end else begin
                    v_cnt_d = v_cnt_q + 1'b1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    // Decoding the next-state counts and registering the result keeps the
    // sync/blank flops on the same edge as the coordinate flops, so the
    // outputs never lag the coordinates they describe.
    always_comb begin
        sync_d = decode_sync(h_cnt_d, v_cnt_d,
                             H_DISP_C, H_SYNC_FIRST, H_SYNC_LAST,
                             V_DISP_C, V_SYNC_FIRST, V_SYNC_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            sync_q       <= '1;   // pixel (0,0): syncs inactive, video on
            frame_tick_q <= 1'b0;
        end else begin
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            sync_q       <= sync_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign pixel_x    = h_cnt_q;
    assign pixel_y    = v_cnt_q;
    assign hsync      = sync_q.hsync;
    assign vsync      = sync_q.vsync;
    assign video_on   = sync_q.video_on;
    assign p_tick     = pix_tick;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
module tb_vga_sync_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       vo;
        logic       hs;
        logic       vs;
        logic       pt;
        logic       ft;
    } obs_t;

    typedef struct {
        int         t;
        logic [9:0] x;
        logic [9:0] y;
        logic       vo;
        logic       hs;
        logic       vs;
        logic       pt;
    } vec_t;

    localparam obs_t RST_OBS = '{x: 10'd0, y: 10'd0, vo: 1'b1, hs: 1'b1,
                                 vs: 1'b1, pt: 1'b0, ft: 1'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    logic [9:0] x_a, y_a, x_b, y_b;
    logic vo_a, hs_a, vs_a, pt_a, ft_a;
    logic vo_b, hs_b, vs_b, pt_b, ft_b;

    // Default 640x480 timing.
    vga_sync_gen dut_a (
        .clk(clk), .reset(rst_a), .pixel_x(x_a), .pixel_y(y_a),
        .video_on(vo_a), .hsync(hs_a), .vsync(vs_a),
        .p_tick(pt_a), .frame_tick(ft_a)
    );

    // Reduced timing: line 12 px (24 clk), frame 7 lines (168 clk).
    vga_sync_gen #(
        .CLK_DIV(2),
        .H_DISPLAY(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) dut_b (
        .clk(clk), .reset(rst_b), .pixel_x(x_b), .pixel_y(y_b),
        .video_on(vo_b), .hsync(hs_b), .vsync(vs_b),
        .p_tick(pt_b), .frame_tick(ft_b)
    );

    obs_t obs_a, obs_b;
    assign obs_a = '{x: x_a, y: y_a, vo: vo_a, hs: hs_a, vs: vs_a, pt: pt_a, ft: ft_a};
    assign obs_b = '{x: x_b, y: y_b, vo: vo_b, hs: hs_b, vs: vs_b, pt: pt_b, ft: ft_b};

    // Clock cycles elapsed since reset release (0 while in reset).
    int t_a = 0;
    int t_b = 0;
    always @(posedge clk or posedge rst_a) if (rst_a) t_a <= 0; else t_a <= t_a + 1;
    always @(posedge clk or posedge rst_b) if (rst_b) t_b <= 0; else t_b <= t_b + 1;

    int total = 0;
    int bad   = 0;
    int hs_run_a = 0;
    int vs_run_b = 0;
    int ft_cnt_b = 0;

    // Raster position follows from elapsed clocks alone.
    function automatic obs_t model(input int t, input int div,
                                   input int hd, input int hf, input int hsw, input int hb,
                                   input int vd, input int vf, input int vsw, input int vb);
        obs_t m;
        int ht  = hd + hf + hsw + hb;
        int vt  = vd + vf + vsw + vb;
        int pix = t / div;
        int x   = pix % ht;
        int y   = (pix / ht) % vt;
        m.x  = 10'(x);
        m.y  = 10'(y);
        m.vo = (x < hd) && (y < vd);
        m.hs = !((x >= hd + hf) && (x < hd + hf + hsw));
        m.vs = !((y >= vd + vf) && (y < vd + vf + vsw));
        m.pt = (t % div) == (div - 1);
        m.ft = (t > 0) && ((t % (div * ht * vt)) == 0);
        return m;
    endfunction

    function automatic obs_t model_a(input int t);
        return model(t, 4, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic obs_t model_b(input int t);
        return model(t, 2, 8, 1, 2, 1, 4, 1, 1, 1);
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got x=%0d y=%0d vo=%b hs=%b vs=%b pt=%b ft=%b, want x=%0d y=%0d vo=%b hs=%b vs=%b pt=%b ft=%b",
                     name, got.x, got.y, got.vo, got.hs, got.vs, got.pt, got.ft,
                     exp.x, exp.y, exp.vo, exp.hs, exp.vs, exp.pt, exp.ft);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    // Advance one clock; sample on the falling edge and check both DUTs.
    task automatic tick();
        @(negedge clk);
        check("model_a", obs_a, model_a(t_a));
        check("model_b", obs_b, model_b(t_b));

        if (rst_a) hs_run_a = -1000000;
        else if (hs_a === 1'b0) hs_run_a++;
        else begin
            if (hs_run_a > 0) check_int("hsync_low_clks_a", hs_run_a, 384);
            hs_run_a = 0;
        end

        if (rst_b) vs_run_b = -1000000;
        else if (vs_b === 1'b0) vs_run_b++;
        else begin
            if (vs_run_b > 0) check_int("vsync_low_clks_b", vs_run_b, 24);
            vs_run_b = 0;
        end

        if (ft_b === 1'b1) ft_cnt_b++;
    endtask

    task automatic wait_a(input int target);
        int n = 0;
        while (t_a != target && n < 20000) begin
            tick();
            n++;
        end
        if (t_a != target) check_int("wait_a_timeout", t_a, target);
    endtask

    vec_t vecs[13];

    initial begin
        obs_t e;
        int n;

        //        t      x    y  vo  hs  vs  pt
        vecs[0]  = '{   3,   0, 0, 1, 1, 1, 1};
        vecs[1]  = '{   4,   1, 0, 1, 1, 1, 0};
        vecs[2]  = '{2559, 639, 0, 1, 1, 1, 1};
        vecs[3]  = '{2560, 640, 0, 0, 1, 1, 0};
        vecs[4]  = '{2623, 655, 0, 0, 1, 1, 1};
        vecs[5]  = '{2624, 656, 0, 0, 0, 1, 0};
        vecs[6]  = '{3007, 751, 0, 0, 0, 1, 1};
        vecs[7]  = '{3008, 752, 0, 0, 1, 1, 0};
        vecs[8]  = '{3199, 799, 0, 0, 1, 1, 1};
        vecs[9]  = '{3200,   0, 1, 1, 1, 1, 0};
        vecs[10] = '{3203,   0, 1, 1, 1, 1, 1};
        vecs[11] = '{6400,   0, 2, 1, 1, 1, 0};
        vecs[12] = '{9599, 799, 2, 0, 1, 1, 1};

        // Reset held for 5 clocks.
        repeat (5) begin
            tick();
            check("reset_state_a", obs_a, RST_OBS);
            check("reset_state_b", obs_b, RST_OBS);
        end
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Table vectors on the default-timing instance.
        foreach (vecs[i]) begin
            wait_a(vecs[i].t);
            e = '{x: vecs[i].x, y: vecs[i].y, vo: vecs[i].vo, hs: vecs[i].hs,
                  vs: vecs[i].vs, pt: vecs[i].pt, ft: 1'b0};
            check($sformatf("vec%0d_t%0d", i, vecs[i].t), obs_a, e);
        end

        // Frame strobes seen on the reduced instance so far.
        check_int("frame_tick_count_b", ft_cnt_b, t_b / 168);

        // Asynchronous reset mid-line on the default instance.
        wait_a(t_a + int'($urandom_range(5, 3000)));
        #2 rst_a = 1'b1;
        #1 check("async_reset_a", obs_a, RST_OBS);
        repeat (3) tick();
        rst_a = 1'b0;
        wait_a(3);
        check_int("restart_first_ptick_a", int'(pt_a), 1);
        wait_a(4);
        check_int("restart_x1_a", int'(x_a), 1);

        // Asynchronous reset at x=9, y=5 on the reduced instance (both syncs low).
        n = 0;
        while ((t_b % 168) != 139 && n < 400) begin
            tick();
            n++;
        end
        e = '{x: 10'd9, y: 10'd5, vo: 1'b0, hs: 1'b0, vs: 1'b0, pt: 1'b1, ft: 1'b0};
        check("pre_reset_b", obs_b, e);
        #2 rst_b = 1'b1;
        #1 check("async_reset_b", obs_b, RST_OBS);
        ft_cnt_b = 0;
        repeat (2) tick();
        rst_b = 1'b0;
        repeat (170) tick();
        check_int("frame_tick_after_reset_b", ft_cnt_b, 1);

        // Random reset pulses on the reduced instance.
        for (int k = 0; k < 2000; k++) begin
            tick();
            if ($urandom_range(0, 99) == 0) begin
                if ($urandom_range(0, 1) == 1) #2 rst_b = 1'b1;
                else rst_b = 1'b1;
                repeat ($urandom_range(1, 3)) tick();
                rst_b = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
